mc_control_fsm: RTL and testbench

Parametrised multicycle MIPS main control unit: a Moore FSM with Mealy gating on memory-ready and ALU overflow.
- Decodes opcode across fetch/decode/execute/memory/writeback states.
- Drives the datapath's packed control word.
- Handles two exceptions: illegal opcode and arithmetic overflow, with Cause/EPC write.
- Successor to the fixed-encoding R-type-only controller. Adds lw/sw/beq/j support, configurable opcode encodings and memory wait-state stalling.
- Sits between the instruction register opcode field and the multicycle datapath.

---
 rtl/mc_control_fsm.sv | 187 ++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control unit.
// Moore state sequencing with mem_ready / overflow gating of the control word.
// Optional feature macro: MC_CTRL_ADDI_EN (adds ADDIEX/ADDIWB states and the
// add-immediate decode; when undefined, OP_ADDI decodes as an illegal opcode).
module mc_control_fsm #(
  parameter int unsigned OPCODE_W = 6,
  parameter logic [OPCODE_W-1:0] OP_RTYPE = 6'h00,
  parameter logic [OPCODE_W-1:0] OP_LW    = 6'h23,
  parameter logic [OPCODE_W-1:0] OP_SW    = 6'h2B,
  parameter logic [OPCODE_W-1:0] OP_BEQ   = 6'h04,
  parameter logic [OPCODE_W-1:0] OP_J     = 6'h02,
  parameter logic [OPCODE_W-1:0] OP_ADDI  = 6'h08
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                overflow,
  input  logic                mem_ready,
  output logic [18:0]         ctrl,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RCOMP   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ILLEGAL = 4'd10,
    S_OVF     = 4'd11,
    S_ADDIEX  = 4'd12,
    S_ADDIWB  = 4'd13
  } state_e;

  // Control word bit positions
  localparam int unsigned B_PC_WRITE      = 18;
  localparam int unsigned B_PC_WRITE_COND = 17;
  localparam int unsigned B_IORD          = 16;
  localparam int unsigned B_MEM_READ      = 15;
  localparam int unsigned B_MEM_WRITE     = 14;
  localparam int unsigned B_IR_WRITE      = 13;
  localparam int unsigned B_MEM_TO_REG    = 12;
  localparam int unsigned B_PC_SRC_LSB    = 10;
  localparam int unsigned B_ALU_OP_LSB    = 8;
  localparam int unsigned B_ALU_SRCB_LSB  = 6;
  localparam int unsigned B_ALU_SRCA      = 5;
  localparam int unsigned B_REG_WRITE     = 4;
  localparam int unsigned B_REG_DST       = 3;
  localparam int unsigned B_INT_CAUSE     = 2;
  localparam int unsigned B_CAUSE_WRITE   = 1;
  localparam int unsigned B_EPC_WRITE     = 0;

  state_e      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [18:0] ctrl_c;

  // Next-state logic; opcode is consulted only in DECODE.
  // is_store_q remembers the lw/sw choice made in DECODE so MEMADR does not
  // re-read an opcode that may have changed since.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        is_store_d = (opcode == OP_SW);
        if (opcode == OP_RTYPE)                      state_d = S_EXEC;
        else if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_BEQ)                   state_d = S_BRANCH;
        else if (opcode == OP_J)                     state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
        else if (opcode == OP_ADDI)                  state_d = S_ADDIEX;
`else
        else if (opcode == OP_ADDI)                  state_d = S_ILLEGAL;
`endif
        else                                         state_d = S_ILLEGAL;
      end
      S_MEMADR:  state_d = is_store_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC:    state_d = S_RCOMP;
      S_RCOMP:   state_d = overflow ? S_OVF : S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_ILLEGAL: state_d = S_FETCH;
      S_OVF:     state_d = S_FETCH;
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = overflow ? S_OVF : S_FETCH;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  // Control word decode from current state, gated by mem_ready / overflow.
  always_comb begin
    ctrl_c = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_c[B_MEM_READ]                          = 1'b1;
        ctrl_c[B_ALU_SRCB_LSB +: 2]                 = 2'b01;
        ctrl_c[B_PC_WRITE]                          = mem_ready;
        ctrl_c[B_IR_WRITE]                          = mem_ready;
      end
      S_DECODE: ctrl_c[B_ALU_SRCB_LSB +: 2]         = 2'b11;
      S_MEMADR: begin
        ctrl_c[B_ALU_SRCA]                          = 1'b1;
        ctrl_c[B_ALU_SRCB_LSB +: 2]                 = 2'b10;
      end
      S_MEMRD: begin
        ctrl_c[B_MEM_READ]                          = 1'b1;
        ctrl_c[B_IORD]                              = 1'b1;
      end
      S_MEMWB: begin
        ctrl_c[B_REG_WRITE]                         = 1'b1;
        ctrl_c[B_MEM_TO_REG]                        = 1'b1;
      end
      S_MEMWR: begin
        ctrl_c[B_MEM_WRITE]                         = 1'b1;
        ctrl_c[B_IORD]                              = 1'b1;
      end
      S_EXEC: begin
        ctrl_c[B_ALU_SRCA]                          = 1'b1;
        ctrl_c[B_ALU_OP_LSB +: 2]                   = 2'b10;
      end
      S_RCOMP: begin
        ctrl_c[B_ALU_SRCA]                          = 1'b1;
        ctrl_c[B_ALU_OP_LSB +: 2]                   = 2'b10;
        ctrl_c[B_REG_DST]                           = 1'b1;
        ctrl_c[B_REG_WRITE]                         = ~overflow;
      end
      S_BRANCH: begin
        ctrl_c[B_ALU_SRCA]                          = 1'b1;
        ctrl_c[B_ALU_OP_LSB +: 2]                   = 2'b01;
        ctrl_c[B_PC_WRITE_COND]                     = 1'b1;
        ctrl_c[B_PC_SRC_LSB +: 2]                   = 2'b01;
      end
      S_JUMP: begin
        ctrl_c[B_PC_WRITE]                          = 1'b1;
        ctrl_c[B_PC_SRC_LSB +: 2]                   = 2'b10;
      end
      S_ILLEGAL, S_OVF: begin
        ctrl_c[B_CAUSE_WRITE]                       = 1'b1;
        ctrl_c[B_EPC_WRITE]                         = 1'b1;
        ctrl_c[B_PC_WRITE]                          = 1'b1;
        ctrl_c[B_PC_SRC_LSB +: 2]                   = 2'b11;
        ctrl_c[B_INT_CAUSE]                         = (state_q == S_OVF);
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX: begin
        ctrl_c[B_ALU_SRCA]                          = 1'b1;
        ctrl_c[B_ALU_SRCB_LSB +: 2]                 = 2'b10;
      end
      S_ADDIWB: begin
        ctrl_c[B_ALU_SRCA]                          = 1'b1;
        ctrl_c[B_ALU_SRCB_LSB +: 2]                 = 2'b10;
        ctrl_c[B_REG_WRITE]                         = ~overflow;
      end
`endif
      default: ctrl_c = '0;
    endcase
  end

  // Reset holds every datapath write strobe low.
  always_comb begin
    ctrl  = reset ? '0 : ctrl_c;
    state = state_q;
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_FETCH;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed vector table, a short
// hand-written reset-abort sequence, then random stimulus against a model.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        overflow;
  logic        mem_ready;
  logic [18:0] ctrl;
  logic [3:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  mc_control_fsm dut (
    .clock     (clk),
    .reset     (reset),
    .opcode    (opcode),
    .overflow  (overflow),
    .mem_ready (mem_ready),
    .ctrl      (ctrl),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Control word fields, from the bit map
  localparam logic [18:0] PCW      = 19'd1 << 18;
  localparam logic [18:0] PCWC     = 19'd1 << 17;
  localparam logic [18:0] IORD     = 19'd1 << 16;
  localparam logic [18:0] MRD      = 19'd1 << 15;
  localparam logic [18:0] MWR      = 19'd1 << 14;
  localparam logic [18:0] IRW      = 19'd1 << 13;
  localparam logic [18:0] M2R      = 19'd1 << 12;
  localparam logic [18:0] PCS_AOUT = 19'd1 << 10;
  localparam logic [18:0] PCS_JMP  = 19'd2 << 10;
  localparam logic [18:0] PCS_EXC  = 19'd3 << 10;
  localparam logic [18:0] AOP_SUB  = 19'd1 << 8;
  localparam logic [18:0] AOP_FN   = 19'd2 << 8;
  localparam logic [18:0] SB_4     = 19'd1 << 6;
  localparam logic [18:0] SB_IMM   = 19'd2 << 6;
  localparam logic [18:0] SB_BR    = 19'd3 << 6;
  localparam logic [18:0] SA       = 19'd1 << 5;
  localparam logic [18:0] RW       = 19'd1 << 4;
  localparam logic [18:0] RDST     = 19'd1 << 3;
  localparam logic [18:0] ICAUSE   = 19'd1 << 2;
  localparam logic [18:0] CW       = 19'd1 << 1;
  localparam logic [18:0] EPCW     = 19'd1;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic        ov;
    logic [3:0]  st;
    logic [18:0] cw;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [5:0] op, input logic mr,
                     input logic ov, input logic [3:0] st, input logic [18:0] cw);
    vec_t v;
    v.rst = rst; v.op = op; v.mr = mr; v.ov = ov; v.st = st; v.cw = cw;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [18:0] act, input logic [18:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%05h, expected 0x%05h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then compare state and ctrl before the next edge.
  task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                      input logic ov, input logic [3:0] st, input logic [18:0] cw,
                      input string nm);
    @(negedge clk);
    reset = rst; opcode = op; mem_ready = mr; overflow = ov;
    #1;
    check({nm, "_state"}, {15'd0, state}, {15'd0, st});
    check({nm, "_ctrl"}, ctrl, cw);
  endtask

  // ---------------- Reference model ----------------
  // Planned sequence of upcoming states; an instruction's whole path is
  // queued when it is decoded, so later opcode changes cannot matter.
  int plan[$];

  function automatic logic [18:0] exp_ctrl(input int st, input logic mr, input logic ov);
    case (st)
      0:       return MRD | SB_4 | (mr ? (PCW | IRW) : 19'd0);
      1:       return SB_BR;
      2:       return SA | SB_IMM;
      3:       return MRD | IORD;
      4:       return RW | M2R;
      5:       return MWR | IORD;
      6:       return SA | AOP_FN;
      7:       return SA | AOP_FN | RDST | (ov ? 19'd0 : RW);
      8:       return SA | AOP_SUB | PCWC | PCS_AOUT;
      9:       return PCW | PCS_JMP;
      10:      return CW | EPCW | PCW | PCS_EXC;
      11:      return CW | EPCW | PCW | PCS_EXC | ICAUSE;
      12:      return SA | SB_IMM;
      13:      return SA | SB_IMM | (ov ? 19'd0 : RW);
      default: return 19'd0;
    endcase
  endfunction

  task automatic model_clock(input logic rst, input logic [5:0] op,
                             input logic mr, input logic ov);
    int cur;
    if (rst) begin
      plan = {0};
      return;
    end
    cur = plan[0];
    if ((cur == 0 || cur == 3 || cur == 5) && !mr) return;
    void'(plan.pop_front());
    if (cur == 0) plan.push_back(1);
    if (cur == 1) begin
      case (op)
        6'h00:   plan = {6, 7};
        6'h23:   plan = {2, 3, 4};
        6'h2B:   plan = {2, 5};
        6'h04:   plan = {8};
        6'h02:   plan = {9};
`ifdef MC_CTRL_ADDI_EN
        6'h08:   plan = {12, 13};
`endif
        default: plan = {10};
      endcase
    end
    if ((cur == 7 || cur == 13) && ov) plan.push_front(11);
    if (plan.size() == 0) plan.push_back(0);
  endtask

  initial begin
    logic [5:0] pool [6];
    reset = 1'b1; opcode = 6'h00; mem_ready = 1'b1; overflow = 1'b0;
    pool[0] = 6'h00; pool[1] = 6'h23; pool[2] = 6'h2B;
    pool[3] = 6'h04; pool[4] = 6'h02; pool[5] = 6'h08;

    // Reset for two cycles, then fetch
    add(1, 6'h00, 1, 0, 0, 19'h00000);
    add(1, 6'h00, 1, 0, 0, 19'h00000);
    add(0, 6'h3F, 1, 0, 0, 19'h4A040);
    // R-type, no overflow
    add(0, 6'h00, 1, 0, 1, 19'h000C0);
    add(0, 6'h3F, 1, 0, 6, 19'h00220);
    add(0, 6'h3F, 1, 0, 7, 19'h00238);
    add(0, 6'h3F, 1, 0, 0, 19'h4A040);
    // R-type with overflow -> exception, then a fetch stall
    add(0, 6'h00, 1, 0, 1, 19'h000C0);
    add(0, 6'h3F, 1, 1, 6, 19'h00220);
    add(0, 6'h3F, 1, 1, 7, 19'h00228);
    add(0, 6'h3F, 1, 1, 11, 19'h40C07);
    add(0, 6'h3F, 0, 0, 0, 19'h08040);
    add(0, 6'h3F, 1, 0, 0, 19'h4A040);
    // lw with 3 wait states; opcode changed after decode
    add(0, 6'h23, 1, 0, 1, 19'h000C0);
    add(0, 6'h2B, 1, 0, 2, 19'h000A0);
    add(0, 6'h2B, 0, 1, 3, 19'h18000);
    add(0, 6'h2B, 0, 1, 3, 19'h18000);
    add(0, 6'h2B, 0, 1, 3, 19'h18000);
    add(0, 6'h2B, 1, 0, 3, 19'h18000);
    add(0, 6'h2B, 1, 0, 4, 19'h01010);
    add(0, 6'h00, 1, 0, 0, 19'h4A040);
    // sw with one wait state
    add(0, 6'h2B, 1, 0, 1, 19'h000C0);
    add(0, 6'h23, 1, 0, 2, 19'h000A0);
    add(0, 6'h23, 0, 0, 5, 19'h14000);
    add(0, 6'h23, 1, 0, 5, 19'h14000);
    add(0, 6'h3F, 1, 0, 0, 19'h4A040);
    // beq, j, illegal
    add(0, 6'h04, 1, 0, 1, 19'h000C0);
    add(0, 6'h3F, 1, 0, 8, 19'h20520);
    add(0, 6'h3F, 1, 0, 0, 19'h4A040);
    add(0, 6'h02, 1, 0, 1, 19'h000C0);
    add(0, 6'h3F, 1, 0, 9, 19'h40800);
    add(0, 6'h3F, 1, 0, 0, 19'h4A040);
    add(0, 6'h3F, 1, 0, 1, 19'h000C0);
    add(0, 6'h3F, 1, 0, 10, 19'h40C03);
    add(0, 6'h3F, 1, 0, 0, 19'h4A040);
    // addi
    add(0, 6'h08, 1, 0, 1, 19'h000C0);
`ifdef MC_CTRL_ADDI_EN
    add(0, 6'h3F, 1, 0, 12, 19'h000A0);
    add(0, 6'h3F, 1, 0, 13, 19'h000B0);
    add(0, 6'h3F, 1, 0, 0, 19'h4A040);
    add(0, 6'h08, 1, 0, 1, 19'h000C0);
    add(0, 6'h3F, 1, 1, 12, 19'h000A0);
    add(0, 6'h3F, 1, 1, 13, 19'h000A0);
    add(0, 6'h3F, 1, 0, 11, 19'h40C07);
`else
    add(0, 6'h3F, 1, 0, 10, 19'h40C03);
`endif
    add(0, 6'h3F, 1, 0, 0, 19'h4A040);
    // Reset while stalled in MEMRD
    add(0, 6'h23, 1, 0, 1, 19'h000C0);
    add(0, 6'h3F, 1, 0, 2, 19'h000A0);
    add(0, 6'h3F, 0, 0, 3, 19'h18000);
    add(1, 6'h3F, 0, 0, 3, 19'h00000);
    add(1, 6'h3F, 0, 0, 0, 19'h00000);
    add(0, 6'h3F, 1, 0, 0, 19'h4A040);

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].op, vecs[i].mr, vecs[i].ov, vecs[i].st, vecs[i].cw,
           $sformatf("vec%0d", i));

    // Hand sequence: reset while stalled in MEMWR aborts the store
    step(0, 6'h2B, 1, 0, 1, 19'h000C0, "sw_abort_decode");
    step(0, 6'h00, 1, 0, 2, 19'h000A0, "sw_abort_memadr");
    step(0, 6'h00, 0, 0, 5, 19'h14000, "sw_abort_stall");
    step(1, 6'h00, 0, 0, 5, 19'h00000, "sw_abort_rst_hi");
    step(1, 6'h00, 1, 0, 0, 19'h00000, "sw_abort_rst_held");
    step(0, 6'h00, 1, 0, 0, 19'h4A040, "sw_abort_refetch");

    // Random stimulus against the model
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_clock(1'b1, 6'h00, 1'b1, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      logic [18:0] exp_cw;
      @(negedge clk);
      reset     = ($urandom_range(0, 63) == 0);
      opcode    = ($urandom_range(0, 7) < 6) ? pool[$urandom_range(0, 5)]
                                             : 6'($urandom_range(0, 63));
      mem_ready = ($urandom_range(0, 3) != 0);
      overflow  = ($urandom_range(0, 2) == 0);
      #1;
      exp_cw = reset ? 19'd0 : exp_ctrl(plan[0], mem_ready, overflow);
      check($sformatf("rnd%0d_state", i), {15'd0, state}, 19'(plan[0]));
      check($sformatf("rnd%0d_ctrl", i), ctrl, exp_cw);
      @(posedge clk);
      model_clock(reset, opcode, mem_ready, overflow);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
